// File: rtl/ysyx_24120013_exec_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with memory-response watchdog.
// Define YSYX_24120013_CTRL_PERF_EN to add the cycle_cnt/inst_cnt performance counters.
module ysyx_24120013_exec_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    input  logic              ifu_rsp_valid,
    output logic              inst_latch_en,
    input  logic              idu_is_load,
    input  logic              idu_is_store,
    input  logic              idu_is_ebreak,
    input  logic              idu_illegal,
    input  logic              idu_rd_wen,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    input  logic              lsu_rsp_valid,
    output logic              rf_wen,
    output logic              pc_update,
    output logic              halt,
    output logic              err,
    output logic [3:0]        state
`ifdef YSYX_24120013_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] inst_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXEC       = 4'd4,
        MEM_REQ    = 4'd5,
        MEM_WAIT   = 4'd6,
        WB         = 4'd7,
        HALT       = 4'd8
    } state_e;

    if (TIMEOUT_W < 2 || PERF_W < 1) begin : g_param_chk
        $error("TIMEOUT_W must be >= 2 and PERF_W >= 1");
    end

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    logic                 halt_q, err_q, err_set;

    // wd_inc is the number of wait cycles elapsed including the current one,
    // so an unanswered wait trips after 2^TIMEOUT_W-1 cycles.
    assign wd_inc = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_set = 1'b0;
        case (state_q)
            IDLE:      state_d = FETCH_REQ;
            FETCH_REQ: if (ifu_req_ready) begin
                state_d = FETCH_WAIT;
                wd_d    = '0;
            end
            FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    state_d = DECODE;
                end else if (wd_inc == '1) begin
                    state_d = HALT;
                    err_set = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            DECODE: begin
                if (idu_illegal) begin
                    state_d = HALT;
                    err_set = 1'b1;
                end else if (idu_is_ebreak) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC:      state_d = (idu_is_load || idu_is_store) ? MEM_REQ : WB;
            MEM_REQ: if (lsu_req_ready) begin
                state_d = MEM_WAIT;
                wd_d    = '0;
            end
            MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = WB;
                end else if (wd_inc == '1) begin
                    state_d = HALT;
                    err_set = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            WB:        state_d = FETCH_REQ;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            halt_q  <= (state_d == HALT);
            err_q   <= err_q | err_set;
        end
    end

    assign ifu_req_valid = (state_q == FETCH_REQ);
    assign inst_latch_en = (state_q == FETCH_WAIT) && ifu_rsp_valid;
    assign lsu_req_valid = (state_q == MEM_REQ);
    assign rf_wen        = (state_q == WB) && idu_rd_wen;
    assign pc_update     = (state_q == WB);
    assign halt          = halt_q;
    assign err           = err_q;
    assign state         = state_q;

`ifdef YSYX_24120013_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_q, inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            if (state_q != IDLE && state_q != HALT) cyc_q <= cyc_q + {{(PERF_W-1){1'b0}}, 1'b1};
            if (state_q == WB) inst_q <= inst_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_cnt = cyc_q;
    assign inst_cnt  = inst_q;
`endif

endmodule

// File: tb/tb_ysyx_24120013_exec_ctrl.sv
// Cycle-level scoreboard bench for the exec controller: vector table plus hand-built corner sequences.
module tb_ysyx_24120013_exec_ctrl;
    localparam int TW = 4;

    localparam logic [8:0] I_IRDY = 9'h100, I_IRSP = 9'h080, I_LD = 9'h040, I_ST = 9'h020,
                           I_EB = 9'h010, I_IL = 9'h008, I_RW = 9'h004, I_LRDY = 9'h002,
                           I_LRSP = 9'h001;
    localparam logic [6:0] O_IRV = 7'h40, O_LAT = 7'h20, O_LRV = 7'h10, O_RF = 7'h08,
                           O_PC = 7'h04, O_H = 7'h02, O_E = 7'h01;

    logic clk = 1'b0, rst = 1'b0;
    logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, inst_latch_en;
    logic idu_is_load, idu_is_store, idu_is_ebreak, idu_illegal, idu_rd_wen;
    logic lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic rf_wen, pc_update, halt, err;
    logic [3:0] state;
`ifdef YSYX_24120013_CTRL_PERF_EN
    logic [31:0] cycle_cnt, inst_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_24120013_exec_ctrl #(.TIMEOUT_W(TW), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid),
        .inst_latch_en(inst_latch_en),
        .idu_is_load(idu_is_load), .idu_is_store(idu_is_store), .idu_is_ebreak(idu_is_ebreak),
        .idu_illegal(idu_illegal), .idu_rd_wen(idu_rd_wen),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .rf_wen(rf_wen), .pc_update(pc_update), .halt(halt), .err(err), .state(state)
`ifdef YSYX_24120013_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
`endif
    );

    typedef struct {
        logic [8:0]  in;
        logic [10:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    vec_t tbl[29];

    function automatic logic [10:0] ex(input logic [3:0] st, input logic [6:0] o);
        return {st, o};
    endfunction

    task automatic drive(input logic [8:0] v);
        {ifu_req_ready, ifu_rsp_valid, idu_is_load, idu_is_store, idu_is_ebreak,
         idu_illegal, idu_rd_wen, lsu_req_ready, lsu_rsp_valid} = v;
    endtask

    task automatic chk(input string name);
        logic [10:0] e, a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        a = {state, ifu_req_valid, inst_latch_en, lsu_req_valid, rf_wen, pc_update, halt, err};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, a[10:7], a[6:0], e[10:7], e[6:0]);
        end
    endtask

    // One clock cycle: inputs applied just after the edge, outputs checked mid-cycle.
    task automatic step(input logic [8:0] v, input logic [10:0] e, input string name);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(e);
        #3;
        chk(name);
    endtask

    // Asynchronous reset pulse inside the current cycle, released before the next edge.
    task automatic do_reset(input logic [8:0] v, input string name);
        drive(v);
        rst = 1'b0;
        #1;
        exp_q.push_back(ex(4'd0, 7'd0));
        chk(name);
        #1;
        rst = 1'b1;
    endtask

`ifdef YSYX_24120013_CTRL_PERF_EN
    task automatic chk_perf(input int cyc, input int ins, input string name);
        checks++;
        if (cycle_cnt !== 32'(cyc) || inst_cnt !== 32'(ins)) begin
            errors++;
            $display("FAIL %s: got cycle_cnt=%0d inst_cnt=%0d, expected %0d %0d",
                     name, cycle_cnt, inst_cnt, cyc, ins);
        end
    endtask
`endif

    initial begin
        int n_cyc, n_ins;
        logic [8:0] r;

        // ALU (rd write), stray fetch response, load with slow LSU, zero-wait store, ebreak
        tbl[0]  = '{I_IRDY,                ex(1, O_IRV)};
        tbl[1]  = '{I_IRSP,                ex(2, O_LAT)};
        tbl[2]  = '{I_RW,                  ex(3, 7'd0)};
        tbl[3]  = '{I_RW,                  ex(4, 7'd0)};
        tbl[4]  = '{I_RW,                  ex(7, O_RF | O_PC)};
        tbl[5]  = '{I_IRSP,                ex(1, O_IRV)};
        tbl[6]  = '{I_IRDY,                ex(1, O_IRV)};
        tbl[7]  = '{I_IRSP,                ex(2, O_LAT)};
        tbl[8]  = '{I_LD | I_RW,           ex(3, 7'd0)};
        tbl[9]  = '{I_LD | I_RW,           ex(4, 7'd0)};
        tbl[10] = '{I_LD | I_LRSP,         ex(5, O_LRV)};
        tbl[11] = '{I_LD,                  ex(5, O_LRV)};
        tbl[12] = '{I_LD,                  ex(5, O_LRV)};
        tbl[13] = '{I_LD | I_LRDY,         ex(5, O_LRV)};
        tbl[14] = '{I_LD | I_LRDY,         ex(6, 7'd0)};
        tbl[15] = '{I_LD,                  ex(6, 7'd0)};
        tbl[16] = '{I_LD | I_LRSP | I_RW,  ex(6, 7'd0)};
        tbl[17] = '{I_LD | I_RW,           ex(7, O_RF | O_PC)};
        tbl[18] = '{I_IRDY,                ex(1, O_IRV)};
        tbl[19] = '{I_IRSP,                ex(2, O_LAT)};
        tbl[20] = '{I_ST,                  ex(3, 7'd0)};
        tbl[21] = '{I_ST,                  ex(4, 7'd0)};
        tbl[22] = '{I_ST | I_LRDY,         ex(5, O_LRV)};
        tbl[23] = '{I_ST | I_LRSP,         ex(6, 7'd0)};
        tbl[24] = '{I_ST,                  ex(7, O_PC)};
        tbl[25] = '{I_IRDY,                ex(1, O_IRV)};
        tbl[26] = '{I_IRSP,                ex(2, O_LAT)};
        tbl[27] = '{I_EB | I_RW,           ex(3, 7'd0)};
        tbl[28] = '{9'd0,                  ex(8, O_H)};

        drive(9'd0);
        #1;
        do_reset(9'd0, "reset_state");
        for (int i = 0; i < 29; i++) step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

        n_cyc = 0;
        n_ins = 0;
        for (int i = 0; i < 29; i++) begin
            if (tbl[i].exp[10:7] != 4'd0 && tbl[i].exp[10:7] != 4'd8) n_cyc++;
            if (tbl[i].exp[10:7] == 4'd7) n_ins++;
        end
`ifdef YSYX_24120013_CTRL_PERF_EN
        chk_perf(n_cyc, n_ins, "perf_at_halt");
`endif
        for (int i = 0; i < 20; i++) begin
            r = 9'($urandom);
            step(r, ex(8, O_H), "halt_hold");
        end
`ifdef YSYX_24120013_CTRL_PERF_EN
        chk_perf(n_cyc, n_ins, "perf_frozen");
`endif

        // fetch watchdog: no response for 15 cycles
        do_reset(I_RW, "reset_from_halt");
        step(I_IRDY, ex(1, O_IRV), "to_req");
        for (int k = 1; k <= 15; k++) step(9'd0, ex(2, 7'd0), $sformatf("to_wait%0d", k));
        step(9'd0, ex(8, O_H | O_E), "timeout_halt");

        // response in the 15th cycle wins, then illegal beats ebreak
        do_reset(9'd0, "reset_from_timeout");
        step(I_IRDY, ex(1, O_IRV), "late_req");
        for (int k = 1; k <= 14; k++) step(9'd0, ex(2, 7'd0), $sformatf("late_wait%0d", k));
        step(I_IRSP, ex(2, O_LAT), "late_rsp");
        step(I_IL | I_EB | I_RW, ex(3, 7'd0), "illegal_dec");
        step(9'd0, ex(8, O_H | O_E), "illegal_halt");

        // reset while waiting on data memory
        do_reset(9'd0, "reset_from_illegal");
        step(I_IRDY, ex(1, O_IRV), "mw_req");
        step(I_IRSP, ex(2, O_LAT), "mw_latch");
        step(I_ST, ex(3, 7'd0), "mw_dec");
        step(I_ST, ex(4, 7'd0), "mw_exec");
        step(I_ST | I_LRDY, ex(5, O_LRV), "mw_mreq");
        step(I_ST | I_RW, ex(6, 7'd0), "mw_wait");
        do_reset(I_ST | I_RW | I_LRSP, "reset_mem_wait");
        step(I_IRDY, ex(1, O_IRV), "post_reset");
        step(I_IRSP, ex(2, O_LAT), "post_reset_fetch");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
